// File: rtl/fc1_pkg.sv
// Shared FC1 layer definitions: scheduler state encoding, default sizing and
// a helper for select/index widths.
package fc1_pkg;

    localparam int FC1_NUM_STATS_DEF  = 3;
    localparam int FC1_SETTLE_CYC_DEF = 8;
    localparam int FC1_STAT_W         = 32;
    localparam int FC1_SEQ_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        READ,
        SEND,
        DONE
    } fc1_intstat_sched_state_e;

    // A single stat still needs a one-bit index.
    function automatic int fc1_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc1_intstat_tmr.sv
// Free-running interval timer: emits a one-cycle tick every 'period' cycles
// while enabled; a period of 0 parks the timer.
module fc1_intstat_tmr (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] tmr;
    logic        run;

    assign run = enable && (period != 32'd0);
    // '>=' rather than '==' so a period lowered below the current count ticks at once.
    assign tick = run && (tmr >= (period - 32'd1));

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (!run || tick) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 32'd1;
        end
    end

endmodule

// File: rtl/fc1_intstat_sched.sv
// FC1 interval-statistics scheduler: pulses the counter latch/clear, waits for the
// pulse to settle in the RX domain, then streams the latched stats as indexed records.
module fc1_intstat_sched
    import fc1_pkg::*;
#(
    parameter int NUM_STATS  = FC1_NUM_STATS_DEF,
    parameter int SETTLE_CYC = FC1_SETTLE_CYC_DEF,
    parameter int IDX_W      = fc1_idx_w(NUM_STATS)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iENABLE,
    input  logic [31:0]      iPERIOD,
    input  logic             iMANUAL_REQ,
    output logic             oINT_STATS_LATCH_CLR,
    output logic [IDX_W-1:0] oSTAT_SEL,
    input  logic [31:0]      iSTAT_DATA,
    output logic             oREC_VALID,
    output logic [31:0]      oREC_DATA,
    output logic [IDX_W-1:0] oREC_IDX,
    output logic [15:0]      oREC_SEQ,
    output logic             oREC_LAST,
    input  logic             iREC_READY,
    output logic             oBUSY,
    output logic [15:0]      oOVERRUN_CNT
);

    localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATS - 1);

    fc1_intstat_sched_state_e state;
    fc1_intstat_sched_state_e state_next;

    logic                  tick;
    logic                  trigger;
    logic [SET_W-1:0]      settle_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  rd_phase;
    logic [FC1_STAT_W-1:0] rec_data;
    logic [IDX_W-1:0]      rec_idx;
    logic                  rec_last;
    logic [FC1_SEQ_W-1:0]  seq;
    logic [15:0]           overrun;

    fc1_intstat_tmr u_tmr (
        .clk    (iCLK),
        .rst    (iRST),
        .enable (iENABLE),
        .period (iPERIOD),
        .tick   (tick)
    );

    // A tick and a manual request in the same cycle form one trigger.
    assign trigger = iENABLE && (tick || iMANUAL_REQ);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    always_comb begin
        state_next           = state;
        oINT_STATS_LATCH_CLR = 1'b0;
        oREC_VALID           = 1'b0;
        oBUSY                = (state != IDLE);
        case (state)
            IDLE: begin
                if (trigger) state_next = LATCH;
            end
            LATCH: begin
                oINT_STATS_LATCH_CLR = 1'b1;
                state_next           = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) state_next = READ;
            end
            READ: begin
                if (rd_phase) state_next = SEND;
            end
            SEND: begin
                oREC_VALID = 1'b1;
                if (iREC_READY) state_next = (idx == LAST_IDX) ? DONE : READ;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // READ spans two cycles: select drives the external mux, then the mux output is captured.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            settle_cnt <= '0;
            idx        <= '0;
            rd_phase   <= 1'b0;
            rec_data   <= '0;
            rec_idx    <= '0;
            rec_last   <= 1'b0;
            seq        <= '0;
            overrun    <= '0;
        end else begin
            if (trigger && (state != IDLE) && (overrun != 16'hFFFF)) begin
                overrun <= overrun + 16'd1;
            end
            case (state)
                LATCH: begin
                    settle_cnt <= SET_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        idx <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                READ: begin
                    rd_phase <= !rd_phase;
                    if (rd_phase) begin
                        rec_data <= iSTAT_DATA;
                        rec_idx  <= idx;
                        rec_last <= (idx == LAST_IDX);
                    end
                end
                SEND: begin
                    if (iREC_READY && (idx != LAST_IDX)) idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    seq <= seq + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign oSTAT_SEL    = idx;
    assign oREC_DATA    = rec_data;
    assign oREC_IDX     = rec_idx;
    assign oREC_SEQ     = seq;
    assign oREC_LAST    = rec_last;
    assign oOVERRUN_CNT = overrun;

endmodule

// File: tb/tb_fc1_intstat_sched.sv
// Directed bench for fc1_intstat_sched: periodic and manual intervals, overrun and
// saturation, back-pressure, async reset mid-record and enable drop mid-sequence.
module tb_fc1_intstat_sched;

    localparam int NS = 3;
    localparam int SC = 8;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [31:0]   period;
    logic          manual_req;
    logic          latch_clr;
    logic [IW-1:0] stat_sel;
    logic [31:0]   stat_data;
    logic          rec_valid;
    logic [31:0]   rec_data;
    logic [IW-1:0] rec_idx;
    logic [15:0]   rec_seq;
    logic          rec_last;
    logic          rec_ready;
    logic          busy;
    logic [15:0]   overrun_cnt;

    logic [31:0] stat_vals [NS];

    int checks         = 0;
    int failures       = 0;
    int cyc_cnt        = 0;
    int n_latch        = 0;
    int last_valid_cyc = 0;

    fc1_intstat_sched #(
        .NUM_STATS  (NS),
        .SETTLE_CYC (SC),
        .IDX_W      (IW)
    ) dut (
        .iCLK                 (clk),
        .iRST                 (rst),
        .iENABLE              (enable),
        .iPERIOD              (period),
        .iMANUAL_REQ          (manual_req),
        .oINT_STATS_LATCH_CLR (latch_clr),
        .oSTAT_SEL            (stat_sel),
        .iSTAT_DATA           (stat_data),
        .oREC_VALID           (rec_valid),
        .oREC_DATA            (rec_data),
        .oREC_IDX             (rec_idx),
        .oREC_SEQ             (rec_seq),
        .oREC_LAST            (rec_last),
        .iREC_READY           (rec_ready),
        .oBUSY                (busy),
        .oOVERRUN_CNT         (overrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External stat mux: output valid one cycle after the select changes.
    always @(posedge clk) begin
        stat_data <= (32'(stat_sel) < NS) ? stat_vals[stat_sel] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (latch_clr === 1'b1) n_latch++;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_latch(input int budget, output int latch_cyc);
        int n = 0;
        while (latch_clr !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        latch_cyc = cyc_cnt;
    endtask

    task automatic manual_pulse(input string tag, output int latch_cyc);
        manual_req = 1'b1;
        cyc();
        manual_req = 1'b0;
        check({tag, "_latch"}, 32'(latch_clr), 32'd1);
        latch_cyc = cyc_cnt;
    endtask

    task automatic expect_rec(input string tag, input int i, input logic [15:0] seq,
                              input int ref_cyc, input int gap);
        int n = 0;
        while (rec_valid !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_gap"},  32'(cyc_cnt - ref_cyc), 32'(gap));
        check({tag, "_data"}, rec_data, stat_vals[i]);
        check({tag, "_idx"},  32'(rec_idx), 32'(i));
        check({tag, "_seq"},  32'(rec_seq), 32'(seq));
        check({tag, "_last"}, 32'(rec_last), (i == NS - 1) ? 32'd1 : 32'd0);
        last_valid_cyc = cyc_cnt;
    endtask

    task automatic full_seq(input string tag, input logic [15:0] seq, input int latch_cyc);
        for (int i = 0; i < NS; i++) begin
            expect_rec($sformatf("%s_r%0d", tag, i), i, seq,
                       (i == 0) ? latch_cyc : last_valid_cyc, (i == 0) ? SC + 3 : 3);
            cyc();
        end
    endtask

    task automatic go_idle(input string tag);
        int n = 0;
        enable     = 1'b0;
        period     = 32'd0;
        manual_req = 1'b0;
        while (busy !== 1'b0 && n < 100) begin
            cyc();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        cyc();
    endtask

    initial begin
        int l0;
        int l1;
        int l2;
        int start;
        int nl;
        int t;

        stat_vals[0] = 32'd5;
        stat_vals[1] = 32'd7;
        stat_vals[2] = 32'd9;
        rst        = 1'b1;
        enable     = 1'b0;
        period     = 32'd0;
        manual_req = 1'b0;
        rec_ready  = 1'b1;

        // Reset state
        repeat (3) cyc();
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_latch", 32'(latch_clr), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_sel",   32'(stat_sel), 32'd0);
        check("rst_seq",   32'(rec_seq), 32'd0);
        check("rst_ovr",   32'(overrun_cnt), 32'd0);
        check("rst_data",  rec_data, 32'd0);
        rst = 1'b0;
        cyc();

        // Periodic intervals, period 100
        enable = 1'b1;
        period = 32'd100;
        start  = cyc_cnt;
        wait_latch(150, l0);
        check("per_first", 32'(l0 - start), 32'd100);
        full_seq("per0", 16'd0, l0);
        wait_latch(150, l1);
        check("per_gap1", 32'(l1 - l0), 32'd100);
        full_seq("per1", 16'd1, l1);
        wait_latch(150, l2);
        check("per_gap2", 32'(l2 - l1), 32'd100);
        full_seq("per2", 16'd2, l2);
        go_idle("per");
        check("per_latches", 32'(n_latch), 32'd3);
        check("per_ovr", 32'(overrun_cnt), 32'd0);

        // Manual request with timer off: exactly one sequence
        enable = 1'b1;
        period = 32'd0;
        manual_pulse("man", l0);
        full_seq("man", 16'd3, l0);
        repeat (150) cyc();
        check("man_single", 32'(n_latch), 32'd4);

        // Tick and manual request in the same cycle
        period = 32'd50;
        start  = cyc_cnt;
        repeat (49) cyc();
        manual_pulse("coin", l0);
        check("coin_at", 32'(l0 - start), 32'd50);
        full_seq("coin", 16'd4, l0);
        go_idle("coin");
        check("coin_latches", 32'(n_latch), 32'd5);
        check("coin_ovr", 32'(overrun_cnt), 32'd0);

        // Period 10 is below the minimum interval: every other tick dropped
        enable = 1'b1;
        period = 32'd10;
        start  = cyc_cnt;
        wait_latch(50, l0);
        check("ovr_first", 32'(l0 - start), 32'd10);
        full_seq("ovr0", 16'd5, l0);
        wait_latch(50, l1);
        check("ovr_gap", 32'(l1 - l0), 32'd20);
        check("ovr_cnt1", 32'(overrun_cnt), 32'd1);
        full_seq("ovr1", 16'd6, l1);
        go_idle("ovr");
        check("ovr_cnt2", 32'(overrun_cnt), 32'd2);

        // Back-pressure: ready low for 40 cycles in SEND
        enable    = 1'b1;
        period    = 32'd0;
        rec_ready = 1'b0;
        manual_pulse("stall", l0);
        expect_rec("stall_r0", 0, 16'd7, l0, SC + 3);
        nl = n_latch;
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("stall_valid", 32'(rec_valid), 32'd1);
            check("stall_data", rec_data, 32'd5);
            check("stall_idx", 32'(rec_idx), 32'd0);
        end
        check("stall_nolatch", 32'(n_latch), 32'(nl));
        rec_ready = 1'b1;
        t = cyc_cnt;
        cyc();
        expect_rec("stall_r1", 1, 16'd7, t, 3);
        cyc();
        expect_rec("stall_r2", 2, 16'd7, last_valid_cyc, 3);
        cyc();
        go_idle("stall");

        // Overrun saturation: trigger every cycle while stalled in SEND
        enable    = 1'b1;
        period    = 32'd0;
        rec_ready = 1'b0;
        manual_pulse("sat", l0);
        expect_rec("sat_r0", 0, 16'd8, l0, SC + 3);
        check("sat_base", 32'(overrun_cnt), 32'd2);
        nl = n_latch;
        period = 32'd1;
        repeat (65532) cyc();
        check("sat_fffe", 32'(overrun_cnt), 32'h0000_FFFE);
        cyc();
        check("sat_ffff", 32'(overrun_cnt), 32'h0000_FFFF);
        cyc();
        check("sat_hold", 32'(overrun_cnt), 32'h0000_FFFF);
        check("sat_valid", 32'(rec_valid), 32'd1);
        check("sat_data", rec_data, 32'd5);
        check("sat_nolatch", 32'(n_latch), 32'(nl));
        period    = 32'd0;
        rec_ready = 1'b1;
        t = cyc_cnt;
        cyc();
        expect_rec("sat_r1", 1, 16'd8, t, 3);
        cyc();
        expect_rec("sat_r2", 2, 16'd8, last_valid_cyc, 3);
        cyc();
        go_idle("sat");
        check("sat_after", 32'(overrun_cnt), 32'h0000_FFFF);

        // Asynchronous reset while record idx 1 is waiting
        enable    = 1'b1;
        period    = 32'd0;
        rec_ready = 1'b1;
        manual_pulse("rst", l0);
        expect_rec("rst_r0", 0, 16'd9, l0, SC + 3);
        cyc();
        rec_ready = 1'b0;
        expect_rec("rst_r1", 1, 16'd9, last_valid_cyc, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(rec_valid), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_latch", 32'(latch_clr), 32'd0);
        check("arst_sel",   32'(stat_sel), 32'd0);
        check("arst_data",  rec_data, 32'd0);
        check("arst_idx",   32'(rec_idx), 32'd0);
        check("arst_seq",   32'(rec_seq), 32'd0);
        check("arst_last",  32'(rec_last), 32'd0);
        check("arst_ovr",   32'(overrun_cnt), 32'd0);
        cyc();
        rst       = 1'b0;
        rec_ready = 1'b1;
        manual_pulse("rst_new", l0);
        full_seq("rst_new", 16'd0, l0);
        go_idle("rst_new");

        // Enable dropped during SETTLE: sequence completes, later triggers blocked
        enable = 1'b1;
        period = 32'd0;
        manual_pulse("en", l0);
        cyc();
        enable = 1'b0;
        check("en_busy", 32'(busy), 32'd1);
        full_seq("en", 16'd1, l0);
        nl = n_latch;
        period     = 32'd30;
        manual_req = 1'b1;
        cyc();
        manual_req = 1'b0;
        repeat (100) cyc();
        check("en_nolatch", 32'(n_latch), 32'(nl));
        check("en_idle", 32'(busy), 32'd0);
        check("en_ovr", 32'(overrun_cnt), 32'd0);

        // Lowering the period below the running count ticks immediately
        period = 32'd100;
        enable = 1'b1;
        repeat (50) cyc();
        period = 32'd10;
        cyc();
        check("lower_tick", 32'(latch_clr), 32'd1);
        l0 = cyc_cnt;
        full_seq("lower", 16'd2, l0);
        go_idle("lower");
        check("lower_ovr", 32'(overrun_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
